life_display: RTL and testbench
===============================

# life_display

Row-scanning LED-matrix driver for the 8x8 Game of Life board. It sits directly downstream of the game state register and consumes its 64-bit board every clock. At the start of each display frame it captures a tear-free snapshot of the board, then multiplexes that snapshot onto an 8x8 matrix one row at a time, with programmable dwell and blanking. It also reports frame boundaries and a frame count to the rest of the design.

## Interface
- DIV, default 1000: clock cycles per row dwell; legal range 2..65535.
- BLANK, default 2: blanking cycles at the start of each row dwell; legal range 1..DIV-1.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- board  in  64  live game state; row r is bits [8r+7:8r], column c of row r is bit 8r+c.
- freeze  in  1  when high, the frame-start snapshot is skipped and the previous image is held.
- row  out  8  one-hot row drive, active high; bit r selects row r.
- col  out  8  column data for the driven row, active high; bit c is column c.
- frame_start  out  1  one-cycle pulse in the cycle the snapshot is taken.
- frame_cnt  out  16  number of frame starts since reset; wraps modulo 2^16.

## Operation
- State registers:
  - div_cnt: 0..DIV-1.
  - row_idx: 0..7.
  - snap: 64 bits.
  - frame_cnt: 16 bits.
- Reset (sampled high at an edge) sets div_cnt=0, row_idx=0, snap=0 and frame_cnt=0.
- While reset is high, these outputs are forced: row=0, col=0, frame_start=0.
- div_cnt advances by 1 each cycle. At DIV-1 it wraps to 0, and row_idx advances by 1. row_idx wraps from 7 to 0.
- frame_start is combinational from state: frame_start = !reset && div_cnt==0 && row_idx==0.
- On an edge where frame_start=1:
  - frame_cnt increments, even when freeze=1. 0xFFFF wraps to 0x0000.
  - If freeze=0, snap <= board. If freeze=1, snap holds.
- Blanking phase (div_cnt < BLANK): row=0, col=0.
- Drive phase (div_cnt >= BLANK):
  - row = 1<<row_idx.
  - col = snap[8*row_idx+7 : 8*row_idx].
- Because BLANK ≥ 1, row 0 is never driven in the snapshot cycle. Row 0 therefore always shows the newly captured board.
- Changes on board between snapshots have no visible effect until the next frame_start.
- The block has no backpressure on the upstream stage. It samples board passively.

## Timing
- Row dwell is DIV cycles. A row is lit for DIV-BLANK of them.
- Frame period is 8*DIV cycles. frame_start recurs every 8*DIV cycles.
- The first cycle after reset deasserts is a frame_start cycle.
  - snap is captured at the end of that cycle, and frame_cnt becomes 1.
  - The first lit row appears BLANK cycles after reset deasserts.
- Snapshot latency: board sampled at edge E is visible on col from cycle E+BLANK (row 0) through the end of the frame.
- row and col change only at row boundaries and at the blank-to-drive transition. No glitching between rows: there is always ≥1 all-zero cycle.
- Reset asserted mid-frame: on the next edge all state returns to reset values, the scan restarts at row 0, and the old snap is discarded (zeros).
- Simultaneous reset and frame_start condition: reset wins. No capture and no count occur.
- freeze toggling mid-frame has no effect. Only its value at the frame_start edge matters.

## Test plan
- Reset release, with DIV=4, BLANK=1, board=64'h0102040810204080:
  - frame_start=1 in cycle 0; row=0, col=0 in cycle 0.
  - In cycle 1: row=8'h01, col=8'h80.
  - In cycle 5: row=8'h02, col=8'h40.
  - frame_cnt=1 after cycle 0.
- Full scan, same parameters: row follows the sequence 01,01,01 (cycles 1-3), then 02 (cycles 5-7), and so on up to 80. It is 0 in cycles 0,4,...,28. frame_start pulses again at cycle 32 and frame_cnt becomes 2.
- Mid-frame board change: board changes to all-ones at cycle 10.
  - col for rows 2..7 keeps the old data through cycle 31.
  - From cycle 33, col=8'hFF for every row.
- Freeze: freeze=1 across cycle 32 with board changed. The display repeats the first image, and frame_cnt still increments to 2.
- Reset mid-frame: reset is pulsed at cycle 13.
  - row=0, col=0 while reset is high.
  - The scan restarts with frame_start in the first cycle after release, and frame_cnt goes to 1.
- Wrap: preload via 65535 frames (or force frame_cnt=16'hFFFF). The next frame_start yields frame_cnt=16'h0000.

Source files
------------

// File: rtl/life_display_if.sv
// rtl/life_display_if.sv - board input and LED-matrix output bundle for life_display
interface life_display_if;
    logic [63:0] board;
    logic        freeze;
    logic [7:0]  row;
    logic [7:0]  col;
    logic        frame_start;
    logic [15:0] frame_cnt;

    modport master (
        output board, freeze,
        input  row, col, frame_start, frame_cnt
    );

    modport slave (
        input  board, freeze,
        output row, col, frame_start, frame_cnt
    );
endinterface

// File: rtl/life_display.sv
// rtl/life_display.sv - row-scanning 8x8 LED driver with frame-start board snapshot
module life_display #(
    parameter int unsigned DIV   = 1000,
    parameter int unsigned BLANK = 2
) (
    input  logic          clk,
    input  logic          reset,
    life_display_if.slave bus
);
    localparam int unsigned DW = $clog2(DIV);

    logic [DW-1:0] div_cnt;
    logic [2:0]    row_idx;
    logic [63:0]   snap;
    logic [15:0]   frame_cnt_q;

    logic          at_wrap;
    logic          frame_start_c;
    logic          blanking;
    logic [7:0]    row_d;
    logic [7:0]    col_d;

    assign at_wrap       = (div_cnt == DW'(DIV - 1));
    assign frame_start_c = !reset && (div_cnt == '0) && (row_idx == 3'd0);
    assign blanking      = (div_cnt < DW'(BLANK));

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt     <= '0;
            row_idx     <= 3'd0;
            snap        <= 64'd0;
            frame_cnt_q <= 16'd0;
        end else begin
            if (at_wrap) begin
                div_cnt <= '0;
                row_idx <= row_idx + 3'd1;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
            // Count every frame even when frozen; only the capture is suppressed.
            if (frame_start_c) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
                if (!bus.freeze) begin
                    snap <= bus.board;
                end
            end
        end
    end

    always_comb begin
        row_d = 8'd0;
        col_d = 8'd0;
        if (!reset && !blanking) begin
            row_d = 8'd1 << row_idx;
            col_d = snap[{row_idx, 3'b000} +: 8];
        end
    end

    assign bus.row         = row_d;
    assign bus.col         = col_d;
    assign bus.frame_start = frame_start_c;
    assign bus.frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_life_display.sv
// tb/tb_life_display.sv - randomized and directed bench for life_display against a frame-position model
module tb_life_display;
    localparam int unsigned DIV   = 4;
    localparam int unsigned BLANK = 1;
    localparam logic [63:0] IMG_A = 64'h0102040810204080;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    life_display_if bus ();

    life_display #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: position in the frame since the last reset, image captured at frame starts.
    int unsigned m_t;
    logic [7:0]  m_img [8];
    logic [15:0] m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [63:0] brd, input logic frz);
        int unsigned pos, r, d;
        logic [7:0]  e_row, e_col;
        logic        e_fs;
        @(negedge clk);
        reset      = rst;
        bus.board  = brd;
        bus.freeze = frz;
        #1;
        pos   = m_t % (8 * DIV);
        r     = pos / DIV;
        d     = pos % DIV;
        e_row = 8'd0;
        e_col = 8'd0;
        e_fs  = 1'b0;
        if (!rst) begin
            e_fs = (pos == 0);
            if (d >= BLANK) begin
                e_row = 8'(1 << r);
                e_col = m_img[r];
            end
        end
        check("row", 64'(bus.row), 64'(e_row));
        check("col", 64'(bus.col), 64'(e_col));
        check("frame_start", 64'(bus.frame_start), 64'(e_fs));
        check("frame_cnt", 64'(bus.frame_cnt), 64'(m_cnt));
        if (rst) begin
            m_t   = 0;
            m_cnt = 16'd0;
            for (int i = 0; i < 8; i++) m_img[i] = 8'd0;
        end else begin
            if (pos == 0) begin
                m_cnt = m_cnt + 16'd1;
                if (!frz) for (int i = 0; i < 8; i++) m_img[i] = brd[8*i +: 8];
            end
            m_t++;
        end
    endtask

    initial begin
        reset      = 1'b1;
        bus.board  = 64'd0;
        bus.freeze = 1'b0;
        m_t   = 0;
        m_cnt = 16'd0;
        for (int i = 0; i < 8; i++) m_img[i] = 8'd0;

        // Reset release, full scan and a mid-frame board change
        step(1'b1, IMG_A, 1'b0);
        step(1'b1, IMG_A, 1'b0);
        for (int c = 0; c < 40; c++) begin
            step(1'b0, (c >= 10) ? ONES : IMG_A, 1'b0);
            if (c == 0) begin
                check("tp_fs0", 64'(bus.frame_start), 64'd1);
                check("tp_row_c0", 64'(bus.row), 64'd0);
            end
            if (c == 1) begin
                check("tp_row_c1", 64'(bus.row), 64'h01);
                check("tp_col_c1", 64'(bus.col), 64'h80);
                check("tp_cnt_c1", 64'(bus.frame_cnt), 64'd1);
            end
            if (c == 5) begin
                check("tp_row_c5", 64'(bus.row), 64'h02);
                check("tp_col_c5", 64'(bus.col), 64'h40);
            end
            if (c == 13) check("tp_old_col_c13", 64'(bus.col), 64'h10);
            if (c == 28) check("tp_blank_c28", 64'(bus.row), 64'd0);
            if (c == 31) check("tp_row_c31", 64'(bus.row), 64'h80);
            if (c == 32) check("tp_fs32", 64'(bus.frame_start), 64'd1);
            if (c == 33) begin
                check("tp_cnt_c33", 64'(bus.frame_cnt), 64'd2);
                check("tp_new_col_c33", 64'(bus.col), 64'hFF);
            end
        end

        // Freeze across the second frame start holds the first image
        step(1'b1, IMG_A, 1'b0);
        for (int c = 0; c < 40; c++) begin
            step(1'b0, (c >= 20) ? ONES : IMG_A, (c == 32) || (c >= 36));
            if (c == 33) begin
                check("frz_cnt", 64'(bus.frame_cnt), 64'd2);
                check("frz_col", 64'(bus.col), 64'h80);
            end
        end

        // Reset pulsed mid-frame
        step(1'b1, IMG_A, 1'b0);
        for (int c = 0; c < 21; c++) begin
            step(c == 13, (c >= 14) ? 64'h00FF_00FF_00FF_00FF : IMG_A, 1'b0);
            if (c == 12) check("rst_cnt_before", 64'(bus.frame_cnt), 64'd1);
            if (c == 13) begin
                check("rst_row", 64'(bus.row), 64'd0);
                check("rst_col", 64'(bus.col), 64'd0);
            end
            if (c == 14) check("rst_fs_after", 64'(bus.frame_start), 64'd1);
            if (c == 15) begin
                check("rst_cnt_after", 64'(bus.frame_cnt), 64'd1);
                check("rst_col_after", 64'(bus.col), 64'hFF);
            end
        end

        // Counter wrap: preload 0xFFFF mid-frame, next frame start yields 0
        force dut.frame_cnt_q = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        m_cnt = 16'hFFFF;
        for (int c = 0; c < 32; c++) step(1'b0, 64'(c), 1'b0);
        check("wrap_cnt", 64'(bus.frame_cnt), 64'd0);

        // Randomized board, freeze and occasional reset
        for (int c = 0; c < 2000; c++) begin
            step($urandom_range(0, 199) == 0, {$urandom, $urandom}, $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
